// File: rtl/audio_sdram_pkg.sv
// Shared types and constants for the audio SDRAM client: FSM states,
// address width and the two-samples-per-word layout.
package audio_sdram_pkg;

  localparam int SDRAM_ADDR_W = 23;

  localparam int LO_LSB = 0;
  localparam int LO_MSB = 15;
  localparam int HI_LSB = 16;
  localparam int HI_MSB = 31;

  localparam logic [15:0] FLUSH_PAD = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REC       = 3'd1,
    ST_REC_FLUSH = 3'd2,
    ST_PLAY      = 3'd3,
    ST_STOP_WAIT = 3'd4
  } state_t;

endpackage

// File: rtl/audio_sdram_client_sample_packer.sv
// Pairs incoming record samples into 32-bit words, holds the word being
// written to SDRAM and flags samples dropped while that write is pending.
module sample_packer
  import audio_sdram_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [15:0] sample,
  input  logic        flush,
  input  logic        write_done,
  output logic [31:0] wr_data,
  output logic        wr_pending,
  output logic        lo_valid,
  output logic        overrun
);

  logic [15:0] lo_word;

  // Pair assembly; a completed pair that finds the write slot busy
  // (including the completion cycle itself) is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lo_word    <= 16'h0000;
      lo_valid   <= 1'b0;
      wr_data    <= 32'h0000_0000;
      wr_pending <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      lo_word  <= 16'h0000;
      lo_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (write_done) begin
        wr_pending <= 1'b0;
      end
      if (accept) begin
        if (!lo_valid) begin
          lo_word  <= sample;
          lo_valid <= 1'b1;
        end else if (wr_pending) begin
          overrun <= 1'b1;
        end else begin
          wr_data[LO_MSB:LO_LSB] <= lo_word;
          wr_data[HI_MSB:HI_LSB] <= sample;
          wr_pending             <= 1'b1;
          lo_valid               <= 1'b0;
        end
      end else if (flush) begin
        wr_data[LO_MSB:LO_LSB] <= lo_word;
        wr_data[HI_MSB:HI_LSB] <= FLUSH_PAD;
        wr_pending             <= 1'b1;
        lo_valid               <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/audio_sdram_client.sv
// Audio record/playback master for the SDRAM bus adapter: records a sample
// stream two-per-word and plays it back to the DAC path on demand.
module audio_sdram_client
  import audio_sdram_pkg::*;
#(
  parameter int                ADDR_W    = SDRAM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0] MAX_ADDR  = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_record,
  input  logic              i_play,
  input  logic              i_stop,
  input  logic              i_sample_valid,
  input  logic [15:0]       i_sample,
  input  logic              i_sample_req,
  output logic [15:0]       o_sample,
  output logic              o_sample_valid,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_read,
  input  logic [31:0]       sdram_readdata,
  output logic              sdram_write,
  output logic [31:0]       sdram_writedata,
  input  logic              sdram_finished,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun,
  output logic              o_underrun
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] end_abs;
  logic [ADDR_W-1:0] end_nx;
  logic              rd_pending;
  logic [31:0]       cur_word;
  logic [31:0]       pf_word;
  logic              cur_valid;
  logic              pf_valid;
  logic              half;
  logic              wr_pending;
  logic              lo_valid;
  logic [31:0]       wr_data;
  logic              overrun;
  logic              wr_done;
  logic              rd_done;
  logic              at_max;
  logic              flush;
  logic              issue_rd;
  logic              play_empty;
  logic              rec_clear;
  logic              play_init;
  logic              done_nx;
  logic              end_load;

  assign end_abs    = BASE_ADDR + o_end_addr;
  assign wr_done    = wr_pending & sdram_finished;
  assign rd_done    = rd_pending & sdram_finished;
  assign at_max     = (addr == MAX_ADDR);
  assign flush      = (state == ST_REC_FLUSH) && !wr_pending && lo_valid;
  assign issue_rd   = (state == ST_PLAY) && !rd_pending && !pf_valid && (addr < end_abs);
  assign play_empty = !rd_pending && !pf_valid && !cur_valid && !(addr < end_abs);

  assign sdram_addr      = addr;
  assign sdram_write     = wr_pending;
  assign sdram_writedata = wr_data;
  assign sdram_read      = rd_pending;
  assign o_overrun       = overrun;

  sample_packer u_packer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .clear      (rec_clear),
    .accept     ((state == ST_REC) && i_sample_valid),
    .sample     (i_sample),
    .flush      (flush),
    .write_done (wr_done),
    .wr_data    (wr_data),
    .wr_pending (wr_pending),
    .lo_valid   (lo_valid),
    .overrun    (overrun)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_nx  = state;
    done_nx   = 1'b0;
    end_load  = 1'b0;
    end_nx    = o_end_addr;
    rec_clear = 1'b0;
    play_init = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_stop) begin
          state_nx = ST_IDLE;
        end else if (i_record) begin
          state_nx  = ST_REC;
          rec_clear = 1'b1;
        end else if (i_play) begin
          state_nx  = ST_PLAY;
          play_init = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_REC: begin
        if (wr_done && at_max) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          end_load = 1'b1;
          end_nx   = MAX_ADDR - BASE_ADDR + ADDR_W'(1);
        end else if (i_stop) begin
          state_nx = ST_REC_FLUSH;
        end else begin
          state_nx = ST_REC;
        end
      end
      ST_REC_FLUSH: begin
        // A full region leaves no room for the padded lone half.
        if (wr_done && at_max) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          end_load = 1'b1;
          end_nx   = MAX_ADDR - BASE_ADDR + ADDR_W'(1);
        end else if (!wr_pending && !lo_valid) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          end_load = 1'b1;
          end_nx   = addr - BASE_ADDR;
        end else begin
          state_nx = ST_REC_FLUSH;
        end
      end
      ST_PLAY: begin
        if (i_stop) begin
          state_nx = ST_STOP_WAIT;
        end else if (play_empty) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = ST_PLAY;
        end
      end
      ST_STOP_WAIT: begin
        if (!rd_pending) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = ST_STOP_WAIT;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Address pointer, read request, playback buffers and status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr           <= {ADDR_W{1'b0}};
      rd_pending     <= 1'b0;
      cur_word       <= 32'h0000_0000;
      pf_word        <= 32'h0000_0000;
      cur_valid      <= 1'b0;
      pf_valid       <= 1'b0;
      half           <= 1'b0;
      o_sample       <= 16'h0000;
      o_sample_valid <= 1'b0;
      o_end_addr     <= {ADDR_W{1'b0}};
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_underrun     <= 1'b0;
    end else begin
      o_done         <= done_nx;
      o_busy         <= (state_nx != ST_IDLE);
      o_sample_valid <= 1'b0;
      if (end_load) begin
        o_end_addr <= end_nx;
      end
      if (rec_clear || play_init) begin
        addr <= BASE_ADDR;
      end else if (wr_done || rd_done) begin
        addr <= addr + ADDR_W'(1);
      end
      if (rd_done) begin
        rd_pending <= 1'b0;
      end else if (issue_rd) begin
        rd_pending <= 1'b1;
      end
      if (play_init) begin
        cur_valid  <= 1'b0;
        pf_valid   <= 1'b0;
        half       <= 1'b0;
        o_underrun <= 1'b0;
      end else if (state == ST_PLAY) begin
        // pf_valid and rd_pending are never both set, so the fill below
        // never collides with a prefetch consume.
        if (rd_done) begin
          pf_word  <= sdram_readdata;
          pf_valid <= 1'b1;
        end
        if (i_sample_req) begin
          o_sample_valid <= 1'b1;
          if (cur_valid) begin
            o_sample <= half ? cur_word[HI_MSB:HI_LSB] : cur_word[LO_MSB:LO_LSB];
            half     <= ~half;
            if (half) begin
              if (pf_valid) begin
                cur_word <= pf_word;
                pf_valid <= 1'b0;
              end else begin
                cur_valid <= 1'b0;
              end
            end
          end else if (pf_valid) begin
            o_sample  <= pf_word[LO_MSB:LO_LSB];
            cur_word  <= pf_word;
            cur_valid <= 1'b1;
            half      <= 1'b1;
            pf_valid  <= 1'b0;
          end else begin
            o_sample   <= 16'h0000;
            o_underrun <= 1'b1;
          end
        end else if (!cur_valid && pf_valid) begin
          cur_word  <= pf_word;
          cur_valid <= 1'b1;
          half      <= 1'b0;
          pf_valid  <= 1'b0;
        end
      end else begin
        cur_valid <= 1'b0;
        pf_valid  <= 1'b0;
        half      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_sdram_client.sv
// Directed bench for audio_sdram_client with a behavioural SDRAM adapter
// (programmable completion latency) and hand-computed expectations.
module tb_audio_sdram_client;
  import audio_sdram_pkg::*;

  localparam int AW = SDRAM_ADDR_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          record, play, stop, sample_valid, sample_req;
  logic [15:0]   sample;
  logic [15:0]   o_sample;
  logic          o_sample_valid;
  logic [AW-1:0] sdram_addr;
  logic          sdram_read, sdram_write, sdram_finished;
  logic [31:0]   sdram_readdata, sdram_writedata;
  logic [AW-1:0] end_addr;
  logic          busy, done, overrun, underrun;

  logic          m_record;
  logic [15:0]   m_sample;
  logic          m_sample_valid;
  logic [AW-1:0] m_addr;
  logic          m_read, m_write, m_finished;
  logic [31:0]   m_writedata;
  logic [AW-1:0] m_end_addr;
  logic          m_busy, m_done, m_overrun, m_underrun;

  int errors = 0;
  int checks = 0;

  logic [31:0]   mem      [0:15];
  logic [AW-1:0] log_addr [0:15];
  logic [31:0]   log_data [0:15];
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  int            lat = 3;
  bit            hold = 1'b0;
  int            wait_cnt = 0;
  int            wr_count = 0;
  int            rd_count = 0;
  int            rd_seen = 0;
  int            done_cnt = 0;
  int            m_wait = 0;
  int            m_wr_count = 0;
  int            m_rd_seen = 0;
  int            m_done_cnt = 0;
  logic [AW-1:0] m_last_addr = '0;
  logic [15:0]   exp_play [0:3];

  always #5 clk = ~clk;

  audio_sdram_client dut (
    .i_clk(clk), .i_rst(rst), .i_record(record), .i_play(play), .i_stop(stop),
    .i_sample_valid(sample_valid), .i_sample(sample), .i_sample_req(sample_req),
    .o_sample(o_sample), .o_sample_valid(o_sample_valid),
    .sdram_addr(sdram_addr), .sdram_read(sdram_read), .sdram_readdata(sdram_readdata),
    .sdram_write(sdram_write), .sdram_writedata(sdram_writedata),
    .sdram_finished(sdram_finished), .o_end_addr(end_addr), .o_busy(busy),
    .o_done(done), .o_overrun(overrun), .o_underrun(underrun)
  );

  audio_sdram_client #(.MAX_ADDR(23'h000003)) dut_max (
    .i_clk(clk), .i_rst(rst), .i_record(m_record), .i_play(1'b0), .i_stop(1'b0),
    .i_sample_valid(sample_valid), .i_sample(sample), .i_sample_req(1'b0),
    .o_sample(m_sample), .o_sample_valid(m_sample_valid),
    .sdram_addr(m_addr), .sdram_read(m_read), .sdram_readdata(32'h0000_0000),
    .sdram_write(m_write), .sdram_writedata(m_writedata),
    .sdram_finished(m_finished), .o_end_addr(m_end_addr), .o_busy(m_busy),
    .o_done(m_done), .o_overrun(m_overrun), .o_underrun(m_underrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] s);
    sample = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_record();
    record = 1'b1;
    @(negedge clk);
    record = 1'b0;
  endtask

  task automatic pulse_play();
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Adapter model for dut: completes after lat cycles unless held, checks
  // that a raised request stays stable and exclusive until completion.
  initial begin
    sdram_finished = 1'b0;
    sdram_readdata = 32'h0000_0000;
    forever begin
      @(negedge clk);
      sdram_finished = 1'b0;
      if (sdram_read) rd_seen++;
      if (rst || !(sdram_write || sdram_read)) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) begin
          req_addr = sdram_addr;
          req_data = sdram_writedata;
        end else begin
          check("hold_addr", 32'(sdram_addr), 32'(req_addr));
          check("hold_data", sdram_writedata, req_data);
          check("rd_wr_excl", {31'h0, sdram_read & sdram_write}, 32'h0);
        end
        wait_cnt++;
        if (!hold && wait_cnt >= lat) begin
          sdram_finished = 1'b1;
          wait_cnt = 0;
          if (sdram_write) begin
            log_addr[wr_count % 16] = sdram_addr;
            log_data[wr_count % 16] = sdram_writedata;
            mem[sdram_addr[3:0]] = sdram_writedata;
            wr_count++;
          end else begin
            sdram_readdata = mem[sdram_addr[3:0]];
            rd_count++;
          end
        end
      end
    end
  end

  // Adapter model for dut_max (fixed two-cycle latency) and done counters.
  initial begin
    m_finished = 1'b0;
    forever begin
      @(negedge clk);
      m_finished = 1'b0;
      if (done) done_cnt++;
      if (m_done) m_done_cnt++;
      if (m_read) m_rd_seen++;
      if (rst || !(m_write || m_read)) begin
        m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait >= 2) begin
          m_finished = 1'b1;
          m_wait = 0;
          if (m_write) begin
            m_wr_count++;
            m_last_addr = m_addr;
          end
        end
      end
    end
  end

  initial begin
    record = 1'b0; play = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    sample_req = 1'b0; sample = 16'h0000; m_record = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    exp_play[0] = 16'hAAAA; exp_play[1] = 16'hBBBB;
    exp_play[2] = 16'h5555; exp_play[3] = 16'h0000;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_wr_rd", {30'h0, sdram_write, sdram_read}, 32'h0);
    check("rst_end", 32'(end_addr), 32'h0);
    check("rst_flags", {29'h0, o_sample_valid, overrun, underrun}, 32'h0);

    // Record four samples, stop.
    done_cnt = 0;
    pulse_record();
    check("rec_busy", {31'h0, busy}, 32'h1);
    send(16'h1111); send(16'h2222); send(16'h3333);
    tick(4);
    send(16'h4444);
    tick(8);
    pulse_stop();
    tick(5);
    check("t1_wr_count", 32'(wr_count), 32'd2);
    check("t1_w0_addr", 32'(log_addr[0]), 32'h0);
    check("t1_w0_data", log_data[0], 32'h2222_1111);
    check("t1_w1_addr", 32'(log_addr[1]), 32'h1);
    check("t1_w1_data", log_data[1], 32'h4444_3333);
    check("t1_end", 32'(end_addr), 32'd2);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_idle", {31'h0, busy}, 32'h0);

    // Odd sample count: lone low half padded on flush.
    done_cnt = 0; rd_seen = 0;
    pulse_record();
    send(16'hAAAA); send(16'hBBBB); send(16'h5555);
    pulse_stop();
    tick(15);
    check("t2_w0_addr", 32'(log_addr[2]), 32'h0);
    check("t2_w0_data", log_data[2], 32'hBBBB_AAAA);
    check("t2_w1_addr", 32'(log_addr[3]), 32'h1);
    check("t2_w1_data", log_data[3], 32'h0000_5555);
    check("t2_end", 32'(end_addr), 32'd2);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_no_read", 32'(rd_seen), 32'd0);

    // Playback, with one early request that finds nothing buffered.
    done_cnt = 0; rd_count = 0;
    pulse_play();
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    check("t3_ur_valid", {31'h0, o_sample_valid}, 32'h1);
    check("t3_ur_sample", {16'h0, o_sample}, 32'h0);
    check("t3_underrun", {31'h0, underrun}, 32'h1);
    tick(6);
    for (int i = 0; i < 4; i++) begin
      sample_req = 1'b1;
      @(negedge clk);
      sample_req = 1'b0;
      check("t3_valid", {31'h0, o_sample_valid}, 32'h1);
      check("t3_sample", {16'h0, o_sample}, {16'h0, exp_play[i]});
      @(negedge clk);
      check("t3_valid_once", {31'h0, o_sample_valid}, 32'h0);
      tick(6);
    end
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_reads", 32'(rd_count), 32'd2);
    check("t3_idle", {31'h0, busy}, 32'h0);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    check("idle_req_ignored", {31'h0, o_sample_valid}, 32'h0);

    // Start priority: stop beats starts, record beats play.
    stop = 1'b1; record = 1'b1; play = 1'b1;
    @(negedge clk);
    stop = 1'b0; record = 1'b0; play = 1'b0;
    tick(2);
    check("prio_stop", {31'h0, busy}, 32'h0);
    check("prio_end_kept", 32'(end_addr), 32'd2);
    rd_seen = 0; done_cnt = 0;
    record = 1'b1; play = 1'b1;
    @(negedge clk);
    record = 1'b0; play = 1'b0;
    tick(4);
    check("prio_rec_busy", {31'h0, busy}, 32'h1);
    check("prio_rec_no_read", 32'(rd_seen), 32'd0);
    pulse_stop();
    tick(4);
    check("empty_rec_end", 32'(end_addr), 32'd0);
    check("empty_rec_done", 32'(done_cnt), 32'd1);

    // Overrun while completion is held off for ~20 cycles.
    hold = 1'b1;
    pulse_record();
    send(16'h1234); send(16'h5678); send(16'h9ABC); send(16'hDEF0);
    tick(10);
    check("t4_overrun", {31'h0, overrun}, 32'h1);
    check("t4_write_held", {31'h0, sdram_write}, 32'h1);
    check("t4_addr", 32'(sdram_addr), 32'h0);
    check("t4_data", sdram_writedata, 32'h5678_1234);
    tick(8);
    hold = 1'b0;
    tick(6);
    pulse_stop();
    tick(10);
    check("t4_w0_data", log_data[4], 32'h5678_1234);
    check("t4_w1_addr", 32'(log_addr[5]), 32'h1);
    check("t4_w1_data", log_data[5], 32'h0000_9ABC);
    check("t4_end", 32'(end_addr), 32'd2);
    check("t4_overrun_sticky", {31'h0, overrun}, 32'h1);

    // Region limit: MAX_ADDR = BASE_ADDR + 3, ten samples offered.
    m_record = 1'b1;
    @(negedge clk);
    m_record = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(16'h0100 + 16'(i));
      tick(4);
    end
    tick(5);
    check("t5_writes", 32'(m_wr_count), 32'd4);
    check("t5_last_addr", 32'(m_last_addr), 32'h3);
    check("t5_done", 32'(m_done_cnt), 32'd1);
    check("t5_end", 32'(m_end_addr), 32'd4);
    check("t5_idle", {29'h0, m_busy, m_overrun, m_underrun}, 32'h0);
    check("t5_no_play", {15'h0, m_sample_valid, m_sample}, 32'h0);
    check("t5_no_read", 32'(m_rd_seen), 32'd0);

    // Reset during a held write, then play an empty recording.
    hold = 1'b1;
    pulse_record();
    send(16'h0101); send(16'h0202);
    tick(3);
    check("t6_pre_write", {31'h0, sdram_write}, 32'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_write", {31'h0, sdram_write}, 32'h0);
    check("t6_rst_addr", 32'(sdram_addr), 32'h0);
    check("t6_rst_wdata", sdram_writedata, 32'h0);
    check("t6_rst_end", 32'(end_addr), 32'h0);
    check("t6_rst_flags", {28'h0, busy, done, overrun, underrun}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    hold = 1'b0;
    tick(1);
    done_cnt = 0; rd_seen = 0;
    pulse_play();
    tick(4);
    check("t6_play_done", 32'(done_cnt), 32'd1);
    check("t6_play_no_read", 32'(rd_seen), 32'd0);
    check("t6_play_idle", {30'h0, busy, underrun}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_sdram_client.md
Name: audio_sdram_client

Overview:
Client-side master for the SDRAM bus adapter. It records a 16-bit audio sample stream into SDRAM, packing two samples per 32-bit word. It plays the recording back on demand to the DAC path. It issues held-level read/write requests and advances only on the adapter's sdram_finished pulse.

Parameters:
ADDR_W, 23, SDRAM word address width
BASE_ADDR, 23'h000000, first word address of the recording region
MAX_ADDR, 23'h7FFFFF, last usable word address (inclusive)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_record  in  1  start-record pulse
i_play  in  1  start-playback pulse
i_stop  in  1  stop pulse
i_sample_valid  in  1  record sample strobe
i_sample  in  16  record sample
i_sample_req  in  1  DAC requests next playback sample
o_sample  out  16  playback sample
o_sample_valid  out  1  playback sample strobe
sdram_addr  out  ADDR_W  request word address
sdram_read  out  1  read request, level
sdram_readdata  in  32  read data, valid with sdram_finished
sdram_write  out  1  write request, level
sdram_writedata  out  32  write data
sdram_finished  in  1  one-cycle completion from the adapter
o_end_addr  out  ADDR_W  words recorded (exclusive end offset from BASE_ADDR)
o_busy  out  1  not IDLE
o_done  out  1  one-cycle pulse when record or play ends
o_overrun  out  1  sticky: a record sample was dropped
o_underrun  out  1  sticky: a play request was served with no data

Behaviour:
- Reset (async): state IDLE; every output 0; internal address, half flags and buffers cleared. Reset mid-request drops the request immediately. The stored recording is not recoverable afterwards (o_end_addr=0).
- States: IDLE, REC, REC_FLUSH, PLAY, STOP_WAIT.
- Start and stop priority in IDLE: i_stop beats both starts; i_record beats i_play. Starts outside IDLE are ignored.
- Request rule:
  - sdram_read and sdram_write are never both 1.
  - Once a request is raised, sdram_addr, sdram_writedata and the request level stay constant until the cycle sdram_finished=1.
  - The request deasserts the cycle after that.
  - Requests are never withdrawn early, including on i_stop.
- REC:
  - Entry clears the write pointer to BASE_ADDR and o_overrun.
  - 1st sample of a pair goes to bits [15:0]; the 2nd goes to [31:16].
  - On the 2nd sample the word moves into the write register and sdram_write rises the next cycle.
  - While a write is pending, one further sample (the next low half) is accepted. A sample that would complete another pair while the write is still pending is dropped and sets o_overrun.
  - On finished: pointer += 1. If the word just written was at MAX_ADDR, go to IDLE, pulse o_done and set o_end_addr = MAX_ADDR-BASE_ADDR+1.
- i_stop in REC:
  - Go to REC_FLUSH. Any pending write completes first.
  - A lone low half is then written with upper half 16'h0000.
  - Then go to IDLE and pulse o_done. o_end_addr = words written.
- PLAY:
  - Entry sets the read pointer to BASE_ADDR and clears o_underrun. If o_end_addr==0, pulse o_done and return to IDLE the next cycle.
  - Buffers: a current word plus a half index, and a one-word prefetch register.
  - A read is issued whenever the prefetch is empty and pointer < BASE_ADDR+o_end_addr.
  - i_sample_req → o_sample_valid=1 exactly one cycle later, with o_sample = low half first, then high half. The current word refills from prefetch in the same cycle as the high half is consumed.
  - A request with no buffered data returns o_sample=0 with valid, and sets o_underrun.
  - Once every word is fetched and consumed: o_done pulse, go to IDLE.
- i_stop in PLAY: go to STOP_WAIT. An outstanding read completes and its data is discarded. Then IDLE with o_done.
- i_sample_req while not in PLAY: ignored, no valid. i_sample_valid while not in REC: ignored.
- The adapter's completion latency is unbounded. All paths wait indefinitely for finished.

Decomposition:
- Package audio_sdram_pkg:
  - state enum
  - ADDR_W and word-layout constants (LO=[15:0], HI=[31:16])
  - FLUSH_PAD=16'h0000
- One sub-module, sample_packer, holds the pair assembly, the pending write word and the overrun detection. The top level holds the FSM, pointers and playback buffers.

Test Plan:
- Record 0x1111,0x2222,0x3333,0x4444, finished 3 cycles after each request, then stop → writes (addr 0, 0x22221111), (addr 1, 0x44443333); o_end_addr=2; o_done pulses once.
- Record 0xAAAA,0xBBBB,0x5555 then stop → addr 1 written 0x00005555; o_end_addr=2; sdram_read never 1.
- Play back the previous recording with i_sample_req every 8 cycles → o_sample sequence AAAA,BBBB,5555,0000; each valid 1 cycle after its req; o_done after the 4th; no further reads.
- Hold sdram_finished low 20 cycles while 4 samples arrive during a pending write → o_overrun=1; 4th sample dropped; address and data held stable throughout.
- Build with MAX_ADDR=BASE_ADDR+3 and record 10 samples → exactly 4 writes; auto stop; o_done; o_end_addr=4.
- Assert i_rst during a held write, then play with o_end_addr=0 → all outputs 0 immediately; play yields immediate o_done and zero reads.
